// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port ids.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  // Requester ids; also the bit position of each port in the grant vector
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // A byte address is word-aligned when its two low bits are zero
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin or fixed D priority on ties, remembering the last winner.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,      // bit 0 = IF, bit 1 = D
  input  logic       mode_i,     // 1 = round-robin on ties, 0 = D always wins ties
  input  logic       advance_i,  // grant is being consumed this cycle
  output logic [1:0] grant_o
);

  logic last_grant_q, last_grant_d;

  // Combinational one-hot grant from current requests and last winner
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
        if (mode_i) begin
          grant_o = (last_grant_q == PORT_IF) ? 2'b10 : 2'b01;
        end else begin
          grant_o = 2'b10;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

  // Remember the winner of every consumed grant, error grants included
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_o[1];
    end
  end

  // Last-grant register; IF counts as the previous winner out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between the IF (read-only) and D (read/write) ports.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK; misaligned requests short-cut IDLE -> ACK.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RR_EN       = 1,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_cs_q, mem_cs_d, mem_oe_q, mem_oe_d, mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic [1:0]        grant;
  logic              win_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_misal;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({d_req, if_req}),
    .mode_i   (RR_EN != 0),
    .advance_i(state_q == ST_IDLE),
    .grant_o  (grant)
  );

  assign win_d     = grant[1];
  assign sel_addr  = win_d ? d_addr : if_addr;
  assign sel_we    = win_d & d_we;
  assign sel_misal = (ALIGN_CHECK != 0) && is_misaligned(sel_addr[1:0]);

  // Next-state and registered-output logic for the access sequencer
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_cs_d   = 1'b0;
    mem_oe_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          port_d = win_d;
          we_d   = sel_we;
          if (sel_misal) begin
            // Reject without touching the RAM; ack immediately with error
            state_d  = ST_ACK;
            if_ack_d = ~win_d;
            if_err_d = ~win_d;
            d_ack_d  = win_d;
            d_err_d  = win_d;
          end else begin
            state_d    = ST_ISSUE;
            mem_addr_d = sel_addr;
            mem_cs_d   = 1'b1;
            mem_oe_d   = ~sel_we;
            mem_we_d   = sel_we;
            if (sel_we) begin
              mem_din_d = d_wdata;
            end
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // RAM registered its output at the end of ISSUE; capture it for reads
        state_d = ST_ACK;
        if (!we_q) begin
          if (port_q == PORT_D) begin
            d_rdata_d = mem_dout;
          end else begin
            if_rdata_d = mem_dout;
          end
        end
        if_ack_d = (port_q == PORT_IF);
        d_ack_d  = (port_q == PORT_D);
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_cs_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_cs_q   <= mem_cs_d;
      mem_oe_q   <= mem_oe_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;
  assign mem_cs   = mem_cs_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a fixed-priority instance,
// each attached to its own behavioural synchronous RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_init;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        d_we;
  logic        rr_if_req, rr_d_req, fp_if_req, fp_d_req;

  logic        rr_if_ack, rr_if_err, rr_d_ack, rr_d_err;
  logic [31:0] rr_if_rdata, rr_d_rdata;
  logic        rr_mem_cs, rr_mem_oe, rr_mem_we, rr_busy;
  logic [31:0] rr_mem_addr, rr_mem_din, rr_mem_dout;

  logic        fp_if_ack, fp_if_err, fp_d_ack, fp_d_err;
  logic [31:0] fp_if_rdata, fp_d_rdata;
  logic        fp_mem_cs, fp_mem_oe, fp_mem_we, fp_busy;
  logic [31:0] fp_mem_addr, fp_mem_din, fp_mem_dout;

  logic [31:0] ram_rr [0:255];
  logic [31:0] ram_fp [0:255];

  int checks = 0;
  int errors = 0;
  int rr_cs_cnt = 0, rr_wr_cnt = 0, rr_d_ack_cnt = 0, rr_if_ack_cnt = 0;
  int cs_base, ack_base;
  logic [1:0] exp_rr, exp_fp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .ALIGN_CHECK(1)) u_rr (
    .clk(clk), .rst(rst),
    .if_req(rr_if_req), .if_addr(if_addr), .if_ack(rr_if_ack), .if_rdata(rr_if_rdata),
    .if_err(rr_if_err),
    .d_req(rr_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(rr_d_ack),
    .d_rdata(rr_d_rdata), .d_err(rr_d_err),
    .mem_cs(rr_mem_cs), .mem_oe(rr_mem_oe), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
    .mem_din(rr_mem_din), .mem_dout(rr_mem_dout), .busy(rr_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .ALIGN_CHECK(1)) u_fp (
    .clk(clk), .rst(rst),
    .if_req(fp_if_req), .if_addr(if_addr), .if_ack(fp_if_ack), .if_rdata(fp_if_rdata),
    .if_err(fp_if_err),
    .d_req(fp_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(fp_d_ack),
    .d_rdata(fp_d_rdata), .d_err(fp_d_err),
    .mem_cs(fp_mem_cs), .mem_oe(fp_mem_oe), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_din(fp_mem_din), .mem_dout(fp_mem_dout), .busy(fp_busy)
  );

  // Behavioural RAMs: word i holds 0x1000_0000 + i after init
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        ram_rr[i] <= 32'h1000_0000 + i;
        ram_fp[i] <= 32'h1000_0000 + i;
      end
    end else begin
      if (rr_mem_cs && rr_mem_we) ram_rr[rr_mem_addr[9:2]] <= rr_mem_din;
      if (rr_mem_cs && rr_mem_oe) rr_mem_dout <= ram_rr[rr_mem_addr[9:2]];
      if (fp_mem_cs && fp_mem_we) ram_fp[fp_mem_addr[9:2]] <= fp_mem_din;
      if (fp_mem_cs && fp_mem_oe) fp_mem_dout <= ram_fp[fp_mem_addr[9:2]];
    end
  end

  // Mid-cycle event counters on the round-robin instance
  always @(negedge clk) begin
    if (rr_mem_cs) rr_cs_cnt++;
    if (rr_mem_cs && rr_mem_we) rr_wr_cnt++;
    if (rr_d_ack) rr_d_ack_cnt++;
    if (rr_if_ack) rr_if_ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    rr_if_req = 1'b0; rr_d_req = 1'b0; fp_if_req = 1'b0; fp_d_req = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    rr_mem_dout = '0; fp_mem_dout = '0;
    tick(); tick();
    rst = 1'b0; ram_init = 1'b0;
    tick();

    // Reset state
    chk("rst_rr_ctl", {rr_if_ack, rr_if_err, rr_d_ack, rr_d_err, rr_mem_cs, rr_mem_oe,
                       rr_mem_we, rr_busy}, 8'h00);
    chk("rst_rr_addr", rr_mem_addr, 32'h0);
    chk("rst_rr_rdata", {rr_if_rdata, rr_d_rdata}, 64'h0);
    chk("rst_fp_ctl", {fp_if_ack, fp_d_ack, fp_mem_cs, fp_busy}, 4'h0);

    // D write 0xDEADBEEF to 0x40
    rr_d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_issue_strobes", {rr_mem_cs, rr_mem_oe, rr_mem_we, rr_busy}, 4'b1011);
    chk("wr_issue_addr", rr_mem_addr, 32'h40);
    chk("wr_issue_din", rr_mem_din, 32'hDEAD_BEEF);
    tick();
    chk("wr_wait_strobes", {rr_mem_cs, rr_mem_oe, rr_mem_we, rr_d_ack}, 4'b0000);
    chk("wr_wait_addr_hold", rr_mem_addr, 32'h40);
    tick();
    chk("wr_ack", {rr_d_ack, rr_d_err, rr_if_ack}, 3'b100);
    tick();
    chk("wr_ack_pulse", rr_d_ack, 1'b0);
    chk("wr_cycle_count", rr_wr_cnt, 1);

    // D read back from 0x40
    d_we = 1'b0; d_addr = 32'h40;
    tick();
    chk("rd_issue_strobes", {rr_mem_cs, rr_mem_oe, rr_mem_we}, 3'b110);
    tick();
    tick();
    chk("rd_ack", {rr_d_ack, rr_d_err}, 2'b10);
    chk("rd_data", rr_d_rdata, 32'hDEAD_BEEF);
    tick();
    rr_d_req = 1'b0;

    // Misaligned D read at 0x42
    cs_base = rr_cs_cnt;
    rr_d_req = 1'b1; d_we = 1'b0; d_addr = 32'h42;
    tick();
    chk("mis_ack_err_cs", {rr_d_ack, rr_d_err, rr_mem_cs}, 3'b110);
    chk("mis_rdata_kept", rr_d_rdata, 32'hDEAD_BEEF);
    tick();
    rr_d_req = 1'b0;
    chk("mis_ack_pulse", rr_d_ack, 1'b0);
    chk("mis_no_ram", rr_cs_cnt, cs_base);

    // Both ports held: round-robin (last winner D) and fixed priority side by side
    if_addr = 32'h0; d_addr = 32'h4; d_we = 1'b0;
    rr_if_req = 1'b1; rr_d_req = 1'b1; fp_if_req = 1'b1; fp_d_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      exp_rr = (k == 2 || k == 10) ? 2'b10 : ((k == 6 || k == 14) ? 2'b01 : 2'b00);
      exp_fp = (k == 2 || k == 6 || k == 10 || k == 14) ? 2'b01 : 2'b00;
      chk($sformatf("rr_ack_k%0d", k), {rr_if_ack, rr_d_ack}, exp_rr);
      chk($sformatf("fp_ack_k%0d", k), {fp_if_ack, fp_d_ack}, exp_fp);
      if (exp_rr[1]) chk($sformatf("rr_if_rdata_k%0d", k), rr_if_rdata, 32'h1000_0000);
      if (exp_rr[0]) chk($sformatf("rr_d_rdata_k%0d", k), rr_d_rdata, 32'h1000_0001);
      if (exp_fp[0]) chk($sformatf("fp_d_rdata_k%0d", k), fp_d_rdata, 32'h1000_0001);
    end
    tick();
    rr_if_req = 1'b0; rr_d_req = 1'b0; fp_d_req = 1'b0;
    // IF finally served on the fixed-priority instance once D lets go
    tick(); tick(); tick();
    chk("fp_if_after_d", {fp_if_ack, fp_d_ack}, 2'b10);
    chk("fp_if_rdata", fp_if_rdata, 32'h1000_0000);
    tick();
    fp_if_req = 1'b0;

    // ACK-cycle hold-off: d_req held through ack plus one cycle
    ack_base = rr_d_ack_cnt; cs_base = rr_cs_cnt;
    rr_d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    tick(); tick(); tick();
    chk("hold_ack1", rr_d_ack, 1'b1);
    tick();
    chk("hold_idle_no_dup", {rr_d_ack, rr_busy, rr_mem_cs}, 3'b000);
    tick();
    chk("hold_reissue", rr_mem_cs, 1'b1);
    rr_d_req = 1'b0;
    tick(); tick();
    chk("hold_ack2", rr_d_ack, 1'b1);
    chk("hold_rdata2", rr_d_rdata, 32'h1000_0001);
    repeat (4) tick();
    chk("hold_ack_count", rr_d_ack_cnt - ack_base, 2);
    chk("hold_access_count", rr_cs_cnt - cs_base, 2);

    // Reset during WAIT of an IF read
    ack_base = rr_if_ack_cnt;
    rr_if_req = 1'b1; if_addr = 32'h0;
    tick(); tick();
    rst = 1'b1; rr_if_req = 1'b0;
    tick();
    chk("rstmid_ctl", {rr_if_ack, rr_if_err, rr_d_ack, rr_d_err, rr_mem_cs, rr_mem_oe,
                       rr_mem_we, rr_busy}, 8'h00);
    chk("rstmid_data", {rr_mem_addr, rr_d_rdata}, 64'h0);
    rst = 1'b0; rr_if_req = 1'b1; if_addr = 32'h8;
    tick();
    chk("rstmid_new_issue", {rr_mem_cs, rr_mem_oe}, 2'b11);
    chk("rstmid_new_addr", rr_mem_addr, 32'h8);
    tick(); tick();
    chk("rstmid_new_ack", rr_if_ack, 1'b1);
    chk("rstmid_new_rdata", rr_if_rdata, 32'h1000_0002);
    tick();
    rr_if_req = 1'b0;
    chk("rstmid_if_ack_count", rr_if_ack_cnt - ack_base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous RAM between two requesters: the instruction-fetch port (IF, read-only) and the load/store data port (D, read/write).
- Sits between the CPU pipeline and the RAM. Drives the RAM's chip-select, output-enable, write-enable, address and write-data inputs, and returns read data through per-port request/acknowledge handshakes.
- Serialises accesses with a 4-state FSM. Ties between the two ports are resolved by round-robin or by fixed priority.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- RR_EN, 1. 1 selects round-robin on ties; 0 gives the D port fixed priority.
- ALIGN_CHECK, 1. 1 rejects word-misaligned addresses (addr[1:0]!=0) with an error response.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF read request; held until if_ack
- if_addr  in  ADDR_W  IF byte address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  IF read data; valid when if_ack=1
- if_err  out  1  misalignment error; qualified by if_ack
- d_req  in  1  D request; held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  D byte address
- d_wdata  in  DATA_W  D write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  D read data; valid when d_ack=1 and the access was a read
- d_err  out  1  misalignment error; qualified by d_ack
- mem_cs  out  1  RAM chip select
- mem_oe  out  1  RAM output enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data; registered by the RAM on the edge that samples cs&oe
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state=IDLE, last_grant=IF.
- Reset asserted mid-operation:
  - The in-flight access is abandoned and no ack is issued.
  - The mem_* strobes are 0 from the first cycle after the reset edge.
  - A write whose ISSUE cycle has already completed is not undone.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise pick a winner (see arbitration) and latch its port id, addr, we and wdata.
  - Misaligned winner with ALIGN_CHECK=1: go to ACK with err=1. No RAM access is made.
  - Any other winner: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_cs=1 and mem_addr=latched addr.
  - Read: mem_oe=1, mem_we=0.
  - Write: mem_we=1, mem_oe=0, mem_din=latched wdata.
  - The RAM samples these at the end of this cycle.
  - Next state: WAIT.
- WAIT (1 cycle):
  - mem_cs=mem_oe=mem_we=0. mem_addr and mem_din hold their values.
  - For a read, mem_dout is captured into the winner's rdata register at the end of the cycle.
  - Next state: ACK.
- ACK (1 cycle):
  - Winner's ack=1 and err as determined in IDLE.
  - The other port's ack stays 0.
  - The loser's rdata is never modified. The winner's rdata is unchanged on a write or an error.
  - New requests are not sampled in this state.
  - Next state: IDLE.
- Latency and throughput:
  - Request sampled at edge E0 gives ack high during cycle E2..E3 (3 cycles).
  - Error path: ack during E0..E1 (1 cycle).
  - Peak throughput is one access per 4 cycles.
- Requester rule: req and its address/data are stable from assertion until the ack cycle. req is deasserted or re-issued (new access) starting the cycle after ack.
- Arbitration, evaluated only in IDLE:
  - Single requester: that requester wins.
  - Both requesting, RR_EN=1: the port that did not win last wins.
  - Both requesting, RR_EN=0: D wins.
  - last_grant updates on every grant, including error grants.
- Write collision is impossible: IF never writes, and accesses are serialised.
- A D write followed by an IF read to the same address returns the new data.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3)
  - port ids PORT_IF=1'b0, PORT_D=1'b1
- Sub-module rr_arb2: 2-way grant with a last_grant register.
  - Inputs: clk, rst, req[1:0], mode, advance.
  - Output: grant one-hot.

Test Plan:
- Write, then read back: D write addr 0x40 data 0xDEADBEEF, then D read addr 0x40.
  - Write: one cycle with mem_cs=1 and mem_we=1; d_ack 3 cycles after req.
  - Read: d_rdata=0xDEADBEEF with d_ack.
- Simultaneous requests, RR_EN=1, held continuously: if_req (addr 0x0) and d_req (read addr 0x4).
  - Grants alternate IF, D, IF, D.
  - Acks spaced 4 cycles apart; if_rdata/d_rdata match the RAM contents at 0x0/0x4.
- Fixed priority: same stimulus with RR_EN=0.
  - D is granted every arbitration.
  - if_ack never asserts while d_req is held.
- Misaligned access: D read addr 0x42 with ALIGN_CHECK=1.
  - d_ack=1 and d_err=1 in the cycle after sampling.
  - mem_cs stays 0 and d_rdata is unchanged.
- Reset mid-access: assert rst during WAIT of an IF read.
  - No if_ack; all outputs 0 next cycle.
  - After release, if_req to 0x8 completes normally in 3 cycles.
- ACK-cycle hold-off: d_req held high through its ack and one extra cycle.
  - Exactly one new access is issued, starting from the IDLE that follows ACK.
  - No duplicate ack.
